// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the shared instruction-ROM read port between IF and DM; DM has priority,
// IF is protected by a starvation counter. Optional range check under ROM_ARB_BOUNDS_EN.
`timescale 1ns/1ps

module rom_fetch_arbiter #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned WAIT_CYCLES  = 0,
   parameter int unsigned STARVE_LIMIT = 3,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000013)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_RVALID,
   output logic [DATA_W-1:0] IF_RDATA,
   input  logic              DM_REQ,
   input  logic [ADDR_W-1:0] DM_ADDR,
   output logic              DM_GNT,
   output logic              DM_RVALID,
   output logic [DATA_W-1:0] DM_RDATA,
   output logic [ADDR_W-1:0] ROM_ADDRESS,
   input  logic [DATA_W-1:0] ROM_DATA,
   output logic              ERR
);

`ifdef ROM_ARB_BOUNDS_EN
   localparam bit BoundsEn = 1'b1;
`else
   localparam bit BoundsEn = 1'b0;
`endif

   typedef enum logic {StIdle, StAccess} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [3:0]        starve;
   logic              owner_dm;
   logic              oob;
   logic              dm_win;
   logic              if_win;
   logic              idle_ok;
   logic              range_err;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] resp_word;

   always_comb begin
      // A saturated starve counter hands the port to IF even when DM is asking.
      dm_win    = DM_REQ && !(IF_REQ && (starve == 4'(STARVE_LIMIT)));
      if_win    = IF_REQ && !dm_win;
      idle_ok   = (state == StIdle) && !RST;
      IF_GNT    = idle_ok && if_win;
      DM_GNT    = idle_ok && dm_win;
      sel_addr  = dm_win ? DM_ADDR : IF_ADDR;
      range_err = BoundsEn && (32'(sel_addr) >= DEPTH);
      resp_word = oob ? NOP_WORD : ROM_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= StIdle;
         cnt         <= '0;
         starve      <= '0;
         owner_dm    <= 1'b0;
         oob         <= 1'b0;
         ROM_ADDRESS <= '0;
         IF_RVALID   <= 1'b0;
         DM_RVALID   <= 1'b0;
         IF_RDATA    <= '0;
         DM_RDATA    <= '0;
         ERR         <= 1'b0;
      end else begin
         IF_RVALID <= 1'b0;
         DM_RVALID <= 1'b0;
         ERR       <= 1'b0;
         unique case (state)
            StIdle: begin
               if (!IF_REQ || IF_GNT) begin
                  starve <= '0;
               end else if (starve != 4'(STARVE_LIMIT)) begin
                  starve <= starve + 4'd1;
               end
               if (IF_GNT || DM_GNT) begin
                  ROM_ADDRESS <= sel_addr;
                  owner_dm    <= DM_GNT;
                  oob         <= range_err;
                  cnt         <= 4'(WAIT_CYCLES);
                  state       <= StAccess;
               end
            end
            StAccess: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= StIdle;
                  ERR   <= oob;
                  if (owner_dm) begin
                     DM_RDATA  <= resp_word;
                     DM_RVALID <= 1'b1;
                  end else begin
                     IF_RDATA  <= resp_word;
                     IF_RVALID <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
